// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: ALU opcode codes as consumed by the execute ALU, the operand-select
// encodings, the packed control word registered by the stage, and the bubble value.
package id_ex_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_LUI  = 4'b1001,
        ALU_JALR = 4'b1010,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    // Operand 1 source. The reserved code behaves exactly like zero.
    typedef enum logic [1:0] {
        IN1_RS1  = 2'b00,
        IN1_PC   = 2'b01,
        IN1_ZERO = 2'b10,
        IN1_RSVD = 2'b11
    } in1_sel_e;

    // Operand 2 source.
    typedef enum logic {
        IN2_RS2 = 1'b0,
        IN2_IMM = 1'b1
    } in2_sel_e;

    // Control word carried from decode into execute.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] alu_op;
        logic [1:0] in1_sel;
        logic       in2_sel;
    } ex_ctrl_t;

    // A bubble is an all-zero control word: no valid, no side effects, ADD opcode.
    localparam ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select: picks the newest in-flight value of one source register.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows its inputs every cycle.
//
// Ports: rs_addr/rs_data (registered source index and register-file value),
// exmem_* and memwb_* (older producers), fwd_data (selected value).
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] rs_addr,
    input  logic [XLEN-1:0] rs_data,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] fwd_data
);

    logic exmem_hit;
    logic memwb_hit;

    // x0 is hardwired to zero, so a producer targeting it never forwards.
    assign exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_addr);
    assign memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_addr);

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    assign fwd_data = exmem_hit ? exmem_result :
                      memwb_hit ? memwb_result :
                                  rs_data;

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with operand forwarding and load-use detection.
// Latency: one cycle from id_* to outputs; forwarding muxes add zero cycles after the register.
// Backpressure: hold_i freezes all state; load_use_stall asks decode/fetch to hold and bubbles EX.
//
// Ports: id_* (decoded instruction), hold_i/flush_i (stall/squash), exmem_*/memwb_*
// (forwarding sources), alu_in1/alu_in2/alu_op/store_data (to ALU and store path),
// ex_* (registered passthrough), load_use_stall (to decode/fetch).
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RA_W-1:0] id_rs1_addr,
    input  logic [RA_W-1:0] id_rs2_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_alu_op,
    input  logic [1:0]      id_in1_sel,
    input  logic            id_in2_sel,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            hold_i,
    input  logic            flush_i,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic            exmem_reg_write,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] store_data,
    output logic            ex_valid,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [XLEN-1:0] ex_pc,
    output logic            load_use_stall
);

    ex_ctrl_t        ctrl_q;
    logic [RA_W-1:0] rd_q;
    logic [RA_W-1:0] rs1_addr_q;
    logic [RA_W-1:0] rs2_addr_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            hit_rs1;
    logic            hit_rs2;

    // ------------------------------------------------------------------
    // Load-use detection: a load in EX cannot forward in time to the
    // instruction in decode. Built only from registered state and id_*;
    // hold_i deliberately has no path here. A flush squashes decode, so
    // there is nothing left to stall.
    // ------------------------------------------------------------------
    assign hit_rs1 = id_uses_rs1 && (id_rs1_addr == rd_q);
    assign hit_rs2 = id_uses_rs2 && (id_rs2_addr == rd_q);

    assign load_use_stall = !flush_i && id_valid && ctrl_q.valid && ctrl_q.mem_read &&
                            (rd_q != '0) && (hit_rs1 || hit_rs2);

    // ------------------------------------------------------------------
    // Pipeline register. Priority: flush, hold, load-use bubble, capture.
    // load_use_stall is already low under flush, so the bubble term only
    // needs gating by hold_i.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= CTRL_BUBBLE;
            rd_q       <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
        end else if (flush_i || (!hold_i && load_use_stall)) begin
            ctrl_q     <= CTRL_BUBBLE;
            rd_q       <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
        end else if (!hold_i) begin
            ctrl_q.valid     <= id_valid;
            ctrl_q.reg_write <= id_reg_write;
            ctrl_q.mem_read  <= id_mem_read;
            ctrl_q.mem_write <= id_mem_write;
            ctrl_q.alu_op    <= id_alu_op;
            ctrl_q.in1_sel   <= id_in1_sel;
            ctrl_q.in2_sel   <= id_in2_sel;
            rd_q             <= id_rd;
            rs1_addr_q       <= id_rs1_addr;
            rs2_addr_q       <= id_rs2_addr;
            pc_q             <= id_pc;
            rs1_data_q       <= id_rs1_data;
            rs2_data_q       <= id_rs2_data;
            imm_q            <= id_imm;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding. Applied regardless of ex_valid; a bubble carries x0
    // addresses and zero data, so its operands stay zero.
    // ------------------------------------------------------------------
    fwd_mux #(
        .XLEN (XLEN),
        .RA_W (RA_W)
    ) u_fwd_rs1 (
        .rs_addr         (rs1_addr_q),
        .rs_data         (rs1_data_q),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rs1)
    );

    fwd_mux #(
        .XLEN (XLEN),
        .RA_W (RA_W)
    ) u_fwd_rs2 (
        .rs_addr         (rs2_addr_q),
        .rs_data         (rs2_data_q),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rs2)
    );

    // ------------------------------------------------------------------
    // Operand selection.
    // ------------------------------------------------------------------
    always_comb begin
        alu_in1 = '0;
        case (ctrl_q.in1_sel)
            IN1_RS1: alu_in1 = fwd_rs1;
            IN1_PC:  alu_in1 = pc_q;
            default: alu_in1 = '0;
        endcase
    end

    assign alu_in2    = (ctrl_q.in2_sel == IN2_IMM) ? imm_q : fwd_rs2;
    assign store_data = fwd_rs2;

    assign alu_op       = ctrl_q.alu_op;
    assign ex_valid     = ctrl_q.valid;
    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_mem_read  = ctrl_q.mem_read;
    assign ex_mem_write = ctrl_q.mem_write;
    assign ex_rd        = rd_q;
    assign ex_pc        = pc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard scenarios plus randomized traffic.
// Expected outputs are computed from a behavioural model of the instruction held in EX.
// A monitor on the falling edge pops one expectation per cycle and compares.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr, id_rs2_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [3:0]  id_alu_op;
    logic [1:0]  id_in1_sel;
    logic        id_in2_sel, id_uses_rs1, id_uses_rs2;
    logic [4:0]  id_rd;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        hold_i, flush_i;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_in1, alu_in2, store_data, ex_pc;
    logic [3:0]  alu_op;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;
    logic [4:0]  ex_rd;

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_in1_sel(id_in1_sel), .id_in2_sel(id_in2_sel),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .hold_i(hold_i), .flush_i(flush_i),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .store_data(store_data),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_pc(ex_pc),
        .load_use_stall(load_use_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the instruction sitting in EX.
    typedef struct packed {
        logic        valid, rw, mr, mw;
        logic [4:0]  rd, a1, a2;
        logic [31:0] pc, d1, d2, imm;
        logic [3:0]  op;
        logic [1:0]  s1;
        logic        s2;
    } ex_t;

    typedef struct packed {
        logic [31:0] in1, in2, sd, pc;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        valid, rw, mr, mw, stall;
    } exp_t;

    ex_t  m;
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Newest architectural value of register a: the youngest in-flight writer wins.
    function automatic logic [31:0] newest(input logic [4:0] a, input logic [31:0] d);
        if (a == 5'd0) return d;
        if (exmem_reg_write && exmem_rd == a) return exmem_result;
        if (memwb_reg_write && memwb_rd == a) return memwb_result;
        return d;
    endfunction

    function automatic logic stall_now();
        logic reads_load;
        reads_load = (id_uses_rs1 && id_rs1_addr == m.rd) || (id_uses_rs2 && id_rs2_addr == m.rd);
        return !flush_i && id_valid && m.valid && m.mr && (m.rd != 5'd0) && reads_load;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        logic [31:0] v1, v2;
        v1 = newest(m.a1, m.d1);
        v2 = newest(m.a2, m.d2);
        e.in1   = (m.s1 == 2'b00) ? v1 : (m.s1 == 2'b01) ? m.pc : 32'd0;
        e.in2   = m.s2 ? m.imm : v2;
        e.sd    = v2;
        e.pc    = m.pc;
        e.op    = m.op;
        e.rd    = m.rd;
        e.valid = m.valid;
        e.rw    = m.rw;
        e.mr    = m.mr;
        e.mw    = m.mw;
        e.stall = stall_now();
        return e;
    endfunction

    // What the stage holds after a rising edge, given the inputs seen at that edge.
    task automatic model_edge();
        if (!rst_n || flush_i) m = '0;
        else if (hold_i) m = m;
        else if (stall_now()) m = '0;
        else begin
            m.valid = id_valid;  m.rw = id_reg_write; m.mr = id_mem_read; m.mw = id_mem_write;
            m.rd = id_rd;        m.a1 = id_rs1_addr;  m.a2 = id_rs2_addr;
            m.pc = id_pc;        m.d1 = id_rs1_data;  m.d2 = id_rs2_data; m.imm = id_imm;
            m.op = id_alu_op;    m.s1 = id_in1_sel;   m.s2 = id_in2_sel;
        end
    endtask

    task automatic set_idle();
        id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_op = 0;
        id_in1_sel = 0; id_in2_sel = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        hold_i = 0; flush_i = 0;
        exmem_rd = 0; memwb_rd = 0; exmem_reg_write = 0; memwb_reg_write = 0;
        exmem_result = 0; memwb_result = 0;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] a1, input logic [31:0] d1,
                             input logic [4:0] a2, input logic [31:0] d2, input logic [31:0] imm,
                             input logic [3:0] op, input logic [1:0] s1, input logic s2,
                             input logic u1, input logic u2, input logic [4:0] rd,
                             input logic rw, input logic mr, input logic mw);
        id_valid = 1; id_pc = pc; id_rs1_addr = a1; id_rs1_data = d1;
        id_rs2_addr = a2; id_rs2_data = d2; id_imm = imm; id_alu_op = op;
        id_in1_sel = s1; id_in2_sel = s2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic rand_inputs();
        id_valid = ($urandom_range(0, 3) != 0);
        id_pc = $urandom & 32'hFFFF_FFFC;
        id_rs1_addr = 5'($urandom_range(0, 7)); id_rs2_addr = 5'($urandom_range(0, 7));
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_alu_op = 4'($urandom_range(0, 15));
        id_in1_sel = 2'($urandom_range(0, 3)); id_in2_sel = 1'($urandom_range(0, 1));
        id_uses_rs1 = 1'($urandom_range(0, 1)); id_uses_rs2 = 1'($urandom_range(0, 1));
        id_rd = 5'($urandom_range(0, 7));
        id_reg_write = 1'($urandom_range(0, 1));
        id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = ($urandom_range(0, 3) == 0);
        hold_i = ($urandom_range(0, 5) == 0); flush_i = ($urandom_range(0, 7) == 0);
        exmem_rd = 5'($urandom_range(0, 7)); memwb_rd = 5'($urandom_range(0, 7));
        exmem_reg_write = 1'($urandom_range(0, 1)); memwb_reg_write = 1'($urandom_range(0, 1));
        exmem_result = $urandom; memwb_result = $urandom;
    endtask

    task automatic begin_cycle();
        @(posedge clk);
        model_edge();
        #1;
        set_idle();
    endtask

    task automatic end_cycle();
        sb_q.push_back(expect_now());
        @(negedge clk);
    endtask

    // Monitor: one expectation per cycle, compared away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("alu_in1", alu_in1, e.in1);
                chk("alu_in2", alu_in2, e.in2);
                chk("store_data", store_data, e.sd);
                chk("ex_pc", ex_pc, e.pc);
                chk("alu_op", 32'(alu_op), 32'(e.op));
                chk("ex_rd", 32'(ex_rd), 32'(e.rd));
                chk("ex_valid", 32'(ex_valid), 32'(e.valid));
                chk("ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
                chk("ex_mem_read", 32'(ex_mem_read), 32'(e.mr));
                chk("ex_mem_write", 32'(ex_mem_write), 32'(e.mw));
                chk("load_use_stall", 32'(load_use_stall), 32'(e.stall));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        m = '0;
        rst_n = 0;
        set_idle();

        // Reset with random decode traffic: everything reads zero.
        repeat (3) begin
            begin_cycle(); rand_inputs(); end_cycle();
        end
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);

        // Release, then ADD x3 = x1 + x2 with 5 and 7.
        begin_cycle(); rst_n = 1;
        set_instr(32'h0, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, ALU_ADD, IN1_RS1, IN2_RS2, 1, 1, 5'd3, 1, 0, 0);
        end_cycle();
        begin_cycle(); end_cycle();
        chk("add_in1", alu_in1, 32'd5);
        chk("add_in2", alu_in2, 32'd7);
        chk("add_op", 32'(alu_op), 32'd0);
        chk("add_valid", 32'(ex_valid), 32'd1);

        // Forward priority on rs1 = x4.
        begin_cycle();
        set_instr(32'h4, 5'd4, 32'h11, 5'd0, 32'd0, 32'd0, ALU_ADD, IN1_RS1, IN2_RS2, 1, 0, 5'd8, 1, 0, 0);
        end_cycle();
        begin_cycle(); hold_i = 1;
        exmem_rd = 5'd4; exmem_reg_write = 1; exmem_result = 32'hAAAA;
        memwb_rd = 5'd4; memwb_reg_write = 1; memwb_result = 32'hBBBB;
        end_cycle();
        chk("fwd_exmem_wins", alu_in1, 32'hAAAA);
        begin_cycle(); hold_i = 1;
        exmem_rd = 5'd4; exmem_reg_write = 0; exmem_result = 32'hAAAA;
        memwb_rd = 5'd4; memwb_reg_write = 1; memwb_result = 32'hBBBB;
        end_cycle();
        chk("fwd_memwb", alu_in1, 32'hBBBB);

        // x0 is never forwarded.
        begin_cycle();
        set_instr(32'h8, 5'd1, 32'd3, 5'd0, 32'd0, 32'd0, ALU_ADD, IN1_RS1, IN2_RS2, 1, 1, 5'd0, 0, 0, 1);
        end_cycle();
        begin_cycle(); exmem_rd = 5'd0; exmem_reg_write = 1; exmem_result = 32'h1234; end_cycle();
        chk("x0_alu_in2", alu_in2, 32'd0);
        chk("x0_store_data", store_data, 32'd0);

        // Load-use on x5.
        begin_cycle();
        set_instr(32'hC, 5'd1, 32'h100, 5'd0, 32'd0, 32'd4, ALU_ADD, IN1_RS1, IN2_IMM, 1, 0, 5'd5, 1, 1, 0);
        end_cycle();
        begin_cycle();
        set_instr(32'h10, 5'd5, 32'd0, 5'd6, 32'd0, 32'd0, ALU_ADD, IN1_RS1, IN2_RS2, 1, 1, 5'd7, 1, 0, 0);
        end_cycle();
        chk("lu_stall", 32'(load_use_stall), 32'd1);
        begin_cycle(); end_cycle();
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
        begin_cycle();
        set_instr(32'h14, 5'd1, 32'h100, 5'd0, 32'd0, 32'd4, ALU_ADD, IN1_RS1, IN2_IMM, 1, 0, 5'd5, 1, 1, 0);
        end_cycle();
        begin_cycle();
        set_instr(32'h18, 5'd5, 32'd0, 5'd6, 32'd0, 32'd0, ALU_ADD, IN1_RS1, IN2_RS2, 0, 1, 5'd7, 1, 0, 0);
        end_cycle();
        chk("lu_no_use", 32'(load_use_stall), 32'd0);

        // Hold keeps state; hold+flush bubbles and suppresses the stall.
        begin_cycle();
        set_instr(32'h40, 5'd1, 32'h100, 5'd0, 32'd0, 32'd4, ALU_ADD, IN1_RS1, IN2_IMM, 1, 0, 5'd5, 1, 1, 0);
        end_cycle();
        begin_cycle();
        set_instr(32'h80, 5'd7, 32'h9, 5'd6, 32'h9, 32'd0, ALU_SUB, IN1_RS1, IN2_RS2, 1, 0, 5'd9, 1, 0, 0);
        hold_i = 1;
        end_cycle();
        begin_cycle();
        set_instr(32'h84, 5'd5, 32'd0, 5'd6, 32'd0, 32'd0, ALU_ADD, IN1_RS1, IN2_RS2, 1, 0, 5'd9, 1, 0, 0);
        hold_i = 1; flush_i = 1;
        end_cycle();
        chk("hold_pc", ex_pc, 32'h40);
        chk("hold_valid", 32'(ex_valid), 32'd1);
        chk("flush_no_stall", 32'(load_use_stall), 32'd0);
        begin_cycle(); end_cycle();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_pc", ex_pc, 32'd0);

        // Operand select: AUIPC then LUI-style.
        begin_cycle();
        set_instr(32'h100, 5'd0, 32'd0, 5'd0, 32'd0, 32'h2000, ALU_ADD, IN1_PC, IN2_IMM, 0, 0, 5'd6, 1, 0, 0);
        end_cycle();
        begin_cycle();
        set_instr(32'h104, 5'd3, 32'h77, 5'd0, 32'd0, 32'h5000, ALU_LUI, IN1_ZERO, IN2_IMM, 0, 0, 5'd6, 1, 0, 0);
        end_cycle();
        chk("auipc_in1", alu_in1, 32'h100);
        chk("auipc_in2", alu_in2, 32'h2000);
        begin_cycle(); end_cycle();
        chk("lui_in1", alu_in1, 32'd0);
        chk("lui_in2", alu_in2, 32'h5000);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            begin_cycle(); rand_inputs(); end_cycle();
        end

        // Mid-stream reset with a valid instruction in EX.
        begin_cycle();
        set_instr(32'h200, 5'd1, 32'h55, 5'd2, 32'h66, 32'h10, ALU_OR, IN1_RS1, IN2_IMM, 1, 1, 5'd4, 1, 0, 1);
        end_cycle();
        begin_cycle(); rand_inputs(); rst_n = 0; m = '0;
        #1;
        chk("midrst_in1", alu_in1, 32'd0);
        chk("midrst_in2", alu_in2, 32'd0);
        chk("midrst_sd", store_data, 32'd0);
        chk("midrst_valid", 32'(ex_valid), 32'd0);
        end_cycle();
        begin_cycle(); rand_inputs(); rst_n = 1; end_cycle();

        for (int i = 0; i < 300; i++) begin
            begin_cycle(); rand_inputs(); end_cycle();
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for the 5-stage RV32I core.
- Captures decoded operands and control, resolves data hazards by forwarding from the EX/MEM and MEM/WB stages, and detects load-use hazards.
- Drives the two ALU operands and the 4-bit ALU op directly into the execute-stage ALU, plus forwarded store data.
- Sits between the decoder/register file and the ALU.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_pc  in  XLEN  PC of the decoded instruction
- id_rs1_addr / id_rs2_addr  in  RA_W  source register indices
- id_rs1_data / id_rs2_data  in  XLEN  register file read data
- id_imm  in  XLEN  sign-extended immediate
- id_alu_op  in  4  ALU opcode, codes as consumed by the ALU
- id_in1_sel  in  2  00=rs1, 01=pc, 10=zero, 11=reserved (treat as zero)
- id_in2_sel  in  1  0=rs2, 1=imm
- id_uses_rs1 / id_uses_rs2  in  1  instruction actually reads the source
- id_rd  in  RA_W  destination register
- id_reg_write / id_mem_read / id_mem_write  in  1  control bits
- hold_i  in  1  downstream stall; freeze this stage
- flush_i  in  1  squash (taken branch/jump resolved)
- exmem_rd, memwb_rd  in  RA_W  destination of older instructions
- exmem_reg_write, memwb_reg_write  in  1
- exmem_result, memwb_result  in  XLEN  values to forward
- alu_in1, alu_in2  out  XLEN  ALU operands
- alu_op  out  4  registered opcode
- store_data  out  XLEN  forwarded rs2 value
- ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_pc  out  registered passthrough
- load_use_stall  out  1  tells decode/fetch to hold

Behaviour:
- Reset: all registered state cleared.
  - ex_valid, ex_reg_write, ex_mem_read, ex_mem_write = 0.
  - alu_op = 4'b0000; ex_rd = 0; ex_pc = 0.
  - All data registers = 0.
  - As a result, alu_in1, alu_in2 and store_data are 0 during reset.
- Register update on each rising edge, priority highest first:
  1. flush_i: insert a bubble.
  2. hold_i: keep all state.
  3. load_use_stall: insert a bubble.
  4. Otherwise: capture all id_* inputs; ex_valid = id_valid.
- Bubble definition:
  - valid, reg_write, mem_read, mem_write = 0.
  - rd = 0; alu_op = 0000.
  - Data fields = 0.
- load_use_stall is combinational. It asserts when all of the following hold:
  - id_valid, ex_valid and ex_mem_read are 1;
  - ex_rd != 0;
  - ((id_uses_rs1 && id_rs1_addr == ex_rd) || (id_uses_rs2 && id_rs2_addr == ex_rd)).
  - It is forced to 0 while flush_i = 1.
  - It depends only on registered state and id_* inputs; no path from hold_i.
- Forwarded rs1 value (combinational from registered rs1 addr/data):
  - Select exmem_result if exmem_reg_write && exmem_rd != 0 && exmem_rd == rs1.
  - Else memwb_result if the same condition holds on the memwb_* inputs.
  - Else the registered rs1 data.
  - EX/MEM always beats MEM/WB. x0 is never forwarded.
- Forwarded rs2 value: same rule. store_data = forwarded rs2.
- alu_in1 = fwd rs1 / ex_pc / 0 according to the registered in1_sel. alu_in2 = fwd rs2 / imm according to the registered in2_sel.
- Zero latency from registered state to outputs; one-cycle latency id_* -> outputs.
- Forwarding is applied even when ex_valid = 0; downstream qualifies with ex_valid.
- Reset asserted mid-operation clears state immediately (asynchronously); the first capture happens on the first edge after rst_n rises.

Decomposition:
- Shared package holds:
  - ALU opcode constants: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, LUI 1001, JALR 1010, SRA 1101.
  - in1_sel/in2_sel encodings.
  - The bubble value.
- One sub-module, fwd_mux, instantiated twice (rs1, rs2): inputs reg addr/data plus both forwarding sources, output the selected value.

Test Plan:
- Reset: rst_n=0 mid-stream with valid state -> all outputs 0 immediately. Release, id_valid=1, ADD x3=x1+x2 with rs1=5, rs2=7 -> next cycle alu_in1=5, alu_in2=7, alu_op=0000, ex_valid=1.
- Forward priority: EX holds rs1=x4.
  - exmem_rd=4 (result 0xAAAA) and memwb_rd=4 (result 0xBBBB), both writing -> alu_in1=0xAAAA.
  - Drop exmem_reg_write -> alu_in1=0xBBBB.
- x0 guard: rs2=x0 with reg data 0, exmem_rd=0, exmem_result=0x1234, reg_write=1 -> alu_in2=0 and store_data=0.
- Load-use: EX holds lw with rd=x5; decode add reads x5 with uses_rs1=1 -> load_use_stall=1 and next cycle ex_valid=0, ex_reg_write=0. Same case with uses_rs1=0 -> no stall.
- Flush/hold priority:
  - hold_i=1 with new id_* -> outputs unchanged.
  - hold_i=1 and flush_i=1 -> bubble; load_use_stall=0 that cycle.
- Operand select: AUIPC with in1_sel=01, in2_sel=1, pc=0x100, imm=0x2000 -> alu_in1=0x100, alu_in2=0x2000. LUI-style in1_sel=10 -> alu_in1=0.
